// File: rtl/uart_pkg.sv
// Shared UART timing constants and the divisor derivation used for reset defaults.
package uart_pkg;

    localparam longint CLOCK_FREQ     = 64'sd100_000_000;
    localparam longint BAUD_RATE      = 64'sd9600;
    localparam int     OVS_DEFAULT    = 32'sd16;
    localparam int     DIV_W_DEFAULT  = 32'sd16;
    localparam int     FRAC_W_DEFAULT = 32'sd4;

    // Divisor expressed in 1/2^frac_w clock units, truncated toward zero.
    function automatic longint calc_div_scaled(input longint clk_hz, input longint baud,
                                               input longint ovs, input longint frac_w);
        return (clk_hz <<< frac_w) / (baud * ovs);
    endfunction

    function automatic int calc_div_int(input longint clk_hz, input longint baud,
                                        input longint ovs, input longint frac_w);
        return int'(calc_div_scaled(clk_hz, baud, ovs, frac_w) >>> frac_w);
    endfunction

    function automatic int calc_div_frac(input longint clk_hz, input longint baud,
                                         input longint ovs, input longint frac_w);
        return int'(calc_div_scaled(clk_hz, baud, ovs, frac_w) & ((64'sd1 <<< frac_w) - 64'sd1));
    endfunction

    localparam int DEF_INT_DEFAULT  = calc_div_int(CLOCK_FREQ, BAUD_RATE,
                                                   longint'(OVS_DEFAULT), longint'(FRAC_W_DEFAULT));
    localparam int DEF_FRAC_DEFAULT = calc_div_frac(CLOCK_FREQ, BAUD_RATE,
                                                    longint'(OVS_DEFAULT), longint'(FRAC_W_DEFAULT));

endpackage

// File: rtl/baud_tick_gen_frac_div_core.sv
// Fractional interval counter: owns cnt, acc and the active divisor, and flags the
// last cycle of each oversample interval.
module frac_div_core
    import uart_pkg::*;
#(
    parameter int DIV_W    = DIV_W_DEFAULT,
    parameter int FRAC_W   = FRAC_W_DEFAULT,
    parameter int DEF_INT  = DEF_INT_DEFAULT,
    parameter int DEF_FRAC = DEF_FRAC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              load,
    input  logic [DIV_W-1:0]  ld_int,
    input  logic [FRAC_W-1:0] ld_frac,
    output logic              interval_end
);

    localparam logic [DIV_W:0] CNT_ZERO = {(DIV_W+1){1'b0}};
    localparam logic [DIV_W:0] CNT_ONE  = {{DIV_W{1'b0}}, 1'b1};

    logic [DIV_W:0]    cnt_r;
    logic [DIV_W:0]    last_r;
    logic [FRAC_W-1:0] acc_r;
    logic [DIV_W-1:0]  act_int_r;
    logic [FRAC_W-1:0] act_frac_r;
    logic [FRAC_W:0]   sum_s;
    logic [DIV_W:0]    last_start_s;
    logic              start_s;

    // Interval length is fixed in its first cycle (cnt==0) from the accumulator carry.
    always_comb begin
        sum_s        = {1'b0, acc_r} + {1'b0, act_frac_r};
        start_s      = (cnt_r == CNT_ZERO);
        last_start_s = {1'b0, act_int_r} + {{DIV_W{1'b0}}, sum_s[FRAC_W]} - CNT_ONE;
        interval_end = !start_s && (cnt_r == last_r);
    end

    // Counter, accumulator and active divisor state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r      <= CNT_ZERO;
            last_r     <= CNT_ONE;
            acc_r      <= {FRAC_W{1'b0}};
            act_int_r  <= DIV_W'(DEF_INT);
            act_frac_r <= FRAC_W'(DEF_FRAC);
        end else begin
            if (load) begin
                act_int_r  <= ld_int;
                act_frac_r <= ld_frac;
            end else begin
                act_int_r  <= act_int_r;
                act_frac_r <= act_frac_r;
            end
            if (clr) begin
                cnt_r <= CNT_ZERO;
                acc_r <= {FRAC_W{1'b0}};
            end else if (start_s) begin
                acc_r  <= sum_s[FRAC_W-1:0];
                last_r <= last_start_s;
                cnt_r  <= cnt_r + CNT_ONE;
            end else if (interval_end) begin
                cnt_r <= CNT_ZERO;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// Programmable oversample/bit tick generator with shadowed divisor updates that
// take effect on interval boundaries.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int DIV_W    = DIV_W_DEFAULT,
    parameter int FRAC_W   = FRAC_W_DEFAULT,
    parameter int OVS      = OVS_DEFAULT,
    parameter int DEF_INT  = DEF_INT_DEFAULT,
    parameter int DEF_FRAC = DEF_FRAC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_wr,
    output logic              os_tick,
    output logic              bit_tick,
    output logic              baud_clk,
    output logic              div_pending
);

    localparam int               OVS_W    = (OVS > 1) ? $clog2(OVS) : 1;
    localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);
    localparam logic [DIV_W-1:0] MIN_INT  = DIV_W'(2);

    function automatic logic [DIV_W-1:0] clamp_int(input logic [DIV_W-1:0] v);
        if (v < MIN_INT) begin
            return MIN_INT;
        end else begin
            return v;
        end
    endfunction

    logic [DIV_W-1:0]  shadow_int_r;
    logic [FRAC_W-1:0] shadow_frac_r;
    logic [OVS_W-1:0]  ovs_cnt_r;
    logic              end_d_r;
    logic              interval_end_s;
    logic              load_s;
    logic              clr_s;
    logic [DIV_W-1:0]  wr_int_s;

    // A pending divisor is applied at a boundary, or at once while disabled.
    always_comb begin
        wr_int_s = clamp_int(div_int);
        clr_s    = !en;
        load_s   = div_pending && (clr_s || interval_end_s);
    end

    frac_div_core #(
        .DIV_W    (DIV_W),
        .FRAC_W   (FRAC_W),
        .DEF_INT  (DEF_INT),
        .DEF_FRAC (DEF_FRAC)
    ) u_core (
        .clk          (clk),
        .reset_n      (reset_n),
        .clr          (clr_s),
        .load         (load_s),
        .ld_int       (shadow_int_r),
        .ld_frac      (shadow_frac_r),
        .interval_end (interval_end_s)
    );

    // Shadow divisor; a write in a boundary cycle lands after that boundary's load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_int_r  <= DIV_W'(DEF_INT);
            shadow_frac_r <= FRAC_W'(DEF_FRAC);
            div_pending   <= 1'b0;
        end else if (div_wr) begin
            shadow_int_r  <= wr_int_s;
            shadow_frac_r <= div_frac;
            div_pending   <= 1'b1;
        end else if (load_s) begin
            div_pending   <= 1'b0;
        end else begin
            div_pending   <= div_pending;
        end
    end

    // Two register stages from the boundary strobe give the first tick at L+1 edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            end_d_r   <= 1'b0;
            os_tick   <= 1'b0;
            bit_tick  <= 1'b0;
            baud_clk  <= 1'b0;
            ovs_cnt_r <= {OVS_W{1'b0}};
        end else if (!en) begin
            end_d_r   <= 1'b0;
            os_tick   <= 1'b0;
            bit_tick  <= 1'b0;
            baud_clk  <= 1'b0;
            ovs_cnt_r <= {OVS_W{1'b0}};
        end else begin
            end_d_r  <= interval_end_s;
            os_tick  <= end_d_r;
            bit_tick <= end_d_r && (ovs_cnt_r == OVS_LAST);
            if (end_d_r) begin
                baud_clk  <= ~baud_clk;
                ovs_cnt_r <= (ovs_cnt_r == OVS_LAST) ? {OVS_W{1'b0}} : ovs_cnt_r + OVS_W'(1);
            end else begin
                baud_clk  <= baud_clk;
                ovs_cnt_r <= ovs_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Scoreboard bench: stimulus queues expected tick spacings, a monitor checks each os_tick.
module tb_baud_tick_gen;

    logic        clk;
    logic        reset_n;
    logic        en;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        div_wr;
    logic        os_tick;
    logic        bit_tick;
    logic        baud_clk;
    logic        div_pending;

    typedef struct {
        int base;
        int gap;
        bit bt;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    baud_tick_gen dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .div_int     (div_int),
        .div_frac    (div_frac),
        .div_wr      (div_wr),
        .os_tick     (os_tick),
        .bit_tick    (bit_tick),
        .baud_clk    (baud_clk),
        .div_pending (div_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic fail(input string name, input int act, input int req);
        n_chk  = n_chk + 1;
        n_fail = n_fail + 1;
        $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic chk(input string name, input int act, input int req);
        if (act != req) begin
            fail(name, act, req);
        end else begin
            n_chk = n_chk + 1;
        end
    endtask

    task automatic push(input int base, input int gap, input bit bt);
        exp_t e;
        e.base = base;
        e.gap  = gap;
        e.bt   = bt;
        exp_q.push_back(e);
    endtask

    task automatic wait_tick(output int t);
        bit seen;
        int waited;
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < 800) begin
            @(negedge clk);
            waited = waited + 1;
            if (os_tick === 1'b1) seen = 1'b1;
        end
        t = cyc;
        if (!seen) fail("os_tick_wait", waited, 800);
    endtask

    task automatic write_div(input logic [15:0] i, input logic [3:0] f);
        div_int  = i;
        div_frac = f;
        div_wr   = 1'b1;
        @(negedge clk);
        div_wr   = 1'b0;
    endtask

    task automatic monitor();
        exp_t e;
        int   gap;
        int   last_tick;
        logic prev_os;
        logic exp_baud;
        last_tick = 0;
        prev_os   = 1'b0;
        exp_baud  = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_os  = 1'b0;
                exp_baud = 1'b0;
            end else begin
                if (os_tick === 1'b1) begin
                    chk("os_tick_back_to_back", int'(prev_os), 0);
                    exp_baud = ~exp_baud;
                    chk("baud_clk_toggle", int'(baud_clk), int'(exp_baud));
                    if (exp_q.size() == 0) begin
                        fail("unexpected_os_tick", cyc, -1);
                    end else begin
                        e   = exp_q.pop_front();
                        gap = (e.base >= 0) ? (cyc - e.base) : (cyc - last_tick);
                        chk("os_tick_spacing", gap, e.gap);
                        chk("bit_tick", int'(bit_tick), int'(e.bt));
                    end
                    last_tick = cyc;
                end else if (bit_tick === 1'b1) begin
                    fail("bit_tick_without_os_tick", 1, 0);
                end
                if (!en) exp_baud = 1'b0;
                prev_os = os_tick;
            end
        end
    endtask

    task automatic stimulus();
        int e0;
        int t;
        int t1;
        int r;

        // Reset defaults, then 651-clock intervals with bit_tick on the 16th
        repeat (3) @(negedge clk);
        chk("reset_os_tick", int'(os_tick), 0);
        chk("reset_bit_tick", int'(bit_tick), 0);
        chk("reset_baud_clk", int'(baud_clk), 0);
        chk("reset_div_pending", int'(div_pending), 0);
        r = cyc;
        push(r, 652, 1'b0);
        for (int i = 2; i <= 16; i++) push(-1, 651, (i == 16));
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) wait_tick(t);
        en = 1'b0;

        // Fractional 4 + 4/16; back-to-back writes while disabled, last one wins
        @(negedge clk);
        div_int  = 16'd7;
        div_frac = 4'd0;
        div_wr   = 1'b1;
        @(negedge clk);
        div_int  = 16'd4;
        div_frac = 4'd4;
        @(negedge clk);
        div_wr   = 1'b0;
        repeat (3) @(negedge clk);
        chk("pending_applied_while_disabled", int'(div_pending), 0);
        e0 = cyc;
        push(e0, 5, 1'b0);
        for (int i = 2; i <= 17; i++) push(-1, ((i % 4) == 0) ? 5 : 4, (i == 16));
        en = 1'b1;
        wait_tick(t1);
        for (int i = 2; i <= 17; i++) wait_tick(t);
        en = 1'b0;
        chk("frac_16_intervals_clocks", t - t1, 68);

        // Mid-interval reprogram and a write coincident with a boundary
        @(negedge clk);
        write_div(16'd10, 4'd0);
        repeat (3) @(negedge clk);
        e0 = cyc;
        push(e0, 11, 1'b0);
        push(-1, 10, 1'b0);
        push(-1, 6, 1'b0);
        en = 1'b1;
        wait_tick(t1);
        repeat (3) @(negedge clk);
        write_div(16'd6, 4'd0);
        chk("pending_after_write", int'(div_pending), 1);
        repeat (4) @(negedge clk);
        chk("pending_before_boundary", int'(div_pending), 1);
        @(negedge clk);
        chk("pending_cleared_at_boundary", int'(div_pending), 0);
        wait_tick(t);
        wait_tick(t);
        push(-1, 6, 1'b0);
        push(-1, 8, 1'b0);
        push(-1, 5, 1'b0);
        push(-1, 5, 1'b0);
        @(negedge clk);
        write_div(16'd8, 4'd0);
        @(negedge clk);
        @(negedge clk);
        write_div(16'd5, 4'd0);
        chk("pending_kept_on_boundary_write", int'(div_pending), 1);
        for (int i = 0; i < 4; i++) wait_tick(t);
        en = 1'b0;
        chk("pending_cleared_final", int'(div_pending), 0);

        // Clamp: int=0 gives 2-clock intervals, baud_clk period 4
        @(negedge clk);
        write_div(16'd0, 4'd0);
        repeat (3) @(negedge clk);
        e0 = cyc;
        push(e0, 3, 1'b0);
        for (int i = 2; i <= 16; i++) push(-1, 2, (i == 16));
        en = 1'b1;
        wait_tick(t);
        wait_tick(t);
        chk("baud_min_p0", int'(baud_clk), 0);
        @(negedge clk);
        chk("baud_min_p1", int'(baud_clk), 0);
        @(negedge clk);
        chk("baud_min_p2", int'(baud_clk), 1);
        @(negedge clk);
        chk("baud_min_p3", int'(baud_clk), 1);
        @(negedge clk);
        chk("baud_min_p4", int'(baud_clk), 0);
        for (int i = 5; i <= 16; i++) wait_tick(t);
        en = 1'b0;
        @(negedge clk);
        write_div(16'd1, 4'd0);
        repeat (3) @(negedge clk);
        e0 = cyc;
        push(e0, 3, 1'b0);
        for (int i = 0; i < 3; i++) push(-1, 2, 1'b0);
        en = 1'b1;
        for (int i = 0; i < 4; i++) wait_tick(t);
        en = 1'b0;

        // Enable gating: drop en mid-interval, then restart from phase 0
        @(negedge clk);
        write_div(16'd7, 4'd0);
        repeat (3) @(negedge clk);
        e0 = cyc;
        push(e0, 8, 1'b0);
        en = 1'b1;
        wait_tick(t1);
        chk("baud_high_after_first_tick", int'(baud_clk), 1);
        repeat (3) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("disable_baud_clk", int'(baud_clk), 0);
        chk("disable_os_tick", int'(os_tick), 0);
        repeat (20) @(negedge clk);
        e0 = cyc;
        push(e0, 8, 1'b0);
        for (int i = 2; i <= 16; i++) push(-1, 7, (i == 16));
        en = 1'b1;
        for (int i = 0; i < 16; i++) wait_tick(t);
        en = 1'b0;

        // Async reset between edges with a write pending
        repeat (2) @(negedge clk);
        e0 = cyc;
        push(e0, 8, 1'b0);
        en = 1'b1;
        repeat (7) @(negedge clk);
        div_int  = 16'd9;
        div_frac = 4'd0;
        div_wr   = 1'b1;
        @(negedge clk);
        div_wr   = 1'b0;
        chk("pre_reset_os_tick", int'(os_tick), 1);
        chk("pre_reset_baud_clk", int'(baud_clk), 1);
        chk("pre_reset_div_pending", int'(div_pending), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_os_tick", int'(os_tick), 0);
        chk("async_reset_baud_clk", int'(baud_clk), 0);
        chk("async_reset_div_pending", int'(div_pending), 0);
        chk("async_reset_bit_tick", int'(bit_tick), 0);
        repeat (2) @(negedge clk);
        r = cyc;
        push(r, 652, 1'b0);
        reset_n = 1'b1;
        wait_tick(t);
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        reset_n  = 1'b0;
        en       = 1'b1;
        div_int  = 16'd0;
        div_frac = 4'd0;
        div_wr   = 1'b0;
        fork
            monitor();
            stimulus();
            begin
                repeat (60000) @(posedge clk);
                fail("global_timeout", cyc, 60000);
            end
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
